// File: rtl/d16_loader_pkg.sv
// d16_loader_pkg: shared types and constants for the blkmem load-packet parser.
package d16_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_ADR_H,
        S_ADR_L,
        S_DAT_H,
        S_DAT_L,
        S_CSUM
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Byte positions of the fixed packet header; data words follow, then the checksum.
    localparam int F_SYNC    = 0;
    localparam int F_LEN_H   = 1;
    localparam int F_LEN_L   = 2;
    localparam int F_ADDR_H  = 3;
    localparam int F_ADDR_L  = 4;
    localparam int HDR_BYTES = 5;

endpackage

// File: rtl/blkmem_loader.sv
// blkmem_loader: parses framed load packets from a UART byte stream and writes
// the assembled 16-bit words into blkmem, with checksum and inter-byte timeout.
module blkmem_loader
    import d16_loader_pkg::*;
#(
    parameter int         DEPTH   = 12,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_dat,
    input  logic             i_rx_valid,
    output logic [15:0]      o_dat,
    output logic [DEPTH-1:0] o_addr,
    output logic             o_we,
    output logic             o_cyc,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [DEPTH-1:0] ptr_q, ptr_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       sum_q, sum_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [15:0]      dat_q, dat_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [15:0]      adr_full;
    logic             tmo_hit;
    logic             sync_hit;
    logic             csum_rx;

    assign adr_full = {hi_q, i_rx_dat};
    // A strobe in the expiry cycle still counts as activity and wins over the timeout.
    assign tmo_hit  = (state_q != S_IDLE) && !i_rx_valid && (tmo_q == TW'(TIMEOUT - 1));
    assign sync_hit = (state_q == S_IDLE) && i_rx_valid && (i_rx_dat == SYNC);
    assign csum_rx  = (state_q == S_CSUM) && i_rx_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        sum_d   = sum_q;
        tmo_d   = (state_q == S_IDLE || i_rx_valid) ? '0 : tmo_q + 1'b1;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else if (i_rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    state_d = sync_hit ? S_LEN_H : S_IDLE;
                    sum_d   = sync_hit ? 8'h00 : sum_q;
                end
                S_LEN_H: begin
                    len_d[15:8] = i_rx_dat;
                    state_d     = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d[7:0] = i_rx_dat;
                    state_d    = S_ADR_H;
                end
                S_ADR_H: begin
                    hi_d    = i_rx_dat;
                    state_d = S_ADR_L;
                end
                S_ADR_L: begin
                    ptr_d   = adr_full[DEPTH-1:0];
                    state_d = (len_q == 16'd0) ? S_CSUM : S_DAT_H;
                end
                S_DAT_H: begin
                    hi_d    = i_rx_dat;
                    sum_d   = sum_q + i_rx_dat;
                    state_d = S_DAT_L;
                end
                S_DAT_L: begin
                    sum_d   = sum_q + i_rx_dat;
                    ptr_d   = ptr_q + 1'b1;
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? S_CSUM : S_DAT_H;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        we_d   = (state_q == S_DAT_L) && i_rx_valid;
        dat_d  = we_d ? {hi_q, i_rx_dat} : dat_q;
        addr_d = we_d ? ptr_q : addr_q;
        busy_d = state_d != S_IDLE;
        done_d = csum_rx && (i_rx_dat == sum_q);
        err_d  = (tmo_hit || (csum_rx && i_rx_dat != sum_q)) ? 1'b1 :
                 sync_hit ? 1'b0 : err_q;
    end

    assign o_dat  = dat_q;
    assign o_addr = addr_q;
    assign o_we   = we_q;
    assign o_cyc  = we_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_blkmem_loader.sv
// tb_blkmem_loader: scoreboard bench for blkmem_loader; expected writes are queued
// as bytes are driven and matched against each observed write cycle.
module tb_blkmem_loader;
    import d16_loader_pkg::*;

    localparam int DEPTH = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_dat = 8'h00;
    logic             rx_valid = 1'b0;
    logic [15:0]      o_dat;
    logic [DEPTH-1:0] o_addr;
    logic             o_we, o_cyc, o_busy, o_done, o_err;

    int checks = 0, failures = 0, we_cnt = 0, done_cnt = 0, gap = 0;
    logic [DEPTH+15:0] exp_q[$];
    logic [DEPTH+15:0] e;
    logic [15:0]       wq[$];
    logic [15:0]       mem [0:(1<<DEPTH)-1];

    blkmem_loader #(.DEPTH(DEPTH), .TIMEOUT(16), .SYNC(8'hA5)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_dat(rx_dat), .i_rx_valid(rx_valid),
        .o_dat(o_dat), .o_addr(o_addr), .o_we(o_we), .o_cyc(o_cyc),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_we || o_cyc) begin
            check("we_eq_cyc", {31'd0, o_cyc}, {31'd0, o_we});
            if (o_we) begin
                we_cnt++;
                mem[o_addr] = o_dat;
                check("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(o_addr), 32'(e[DEPTH+15:16]));
                    check("wr_dat", 32'(o_dat), 32'(e[15:0]));
                end
            end
        end
        if (o_done) done_cnt++;
    end

    task automatic send(input logic [7:0] b);
        rx_dat   = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [15:0] start, input bit bad);
        logic [7:0]       cs;
        logic [DEPTH-1:0] a;
        cs = 8'h00;
        a  = start[DEPTH-1:0];
        send(8'hA5);
        check("busy_after_sync", {31'd0, o_busy}, 32'd1);
        check("err_clr_on_sync", {31'd0, o_err}, 32'd0);
        send(8'(wq.size() >> 8));
        send(8'(wq.size()));
        send(start[15:8]);
        send(start[7:0]);
        foreach (wq[i]) begin
            exp_q.push_back({a, wq[i]});
            a  = a + 1'b1;
            cs = cs + wq[i][15:8] + wq[i][7:0];
            send(wq[i][15:8]);
            send(wq[i][7:0]);
        end
        check("busy_before_csum", {31'd0, o_busy}, 32'd1);
        send(bad ? ~cs : cs);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0, w0;
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(o_dat), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_we", {31'd0, o_we}, 32'd0);
        check("rst_cyc", {31'd0, o_cyc}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word load with back-to-back strobes (a byte lands in each write cycle).
        gap = 0; d0 = done_cnt; w0 = we_cnt;
        wq = {16'h1234, 16'hABCD};
        send_pkt(16'h0010, 1'b0);
        check("good_done", 32'(done_cnt - d0), 32'd1);
        check("good_writes", 32'(we_cnt - w0), 32'd2);
        check("good_err", {31'd0, o_err}, 32'd0);
        check("good_busy", {31'd0, o_busy}, 32'd0);
        check("mem_010", 32'(mem[12'h010]), 32'h1234);
        check("mem_011", 32'(mem[12'h011]), 32'hABCD);

        gap = 2; d0 = done_cnt; w0 = we_cnt;
        send_pkt(16'h0010, 1'b1);
        check("bad_done", 32'(done_cnt - d0), 32'd0);
        check("bad_writes", 32'(we_cnt - w0), 32'd2);
        check("bad_err", {31'd0, o_err}, 32'd1);
        check("bad_busy", {31'd0, o_busy}, 32'd0);

        gap = 1; d0 = done_cnt; w0 = we_cnt;
        wq = {};
        send_pkt(16'h0000, 1'b0);
        check("zero_done", 32'(done_cnt - d0), 32'd1);
        check("zero_writes", 32'(we_cnt - w0), 32'd0);
        check("zero_err", {31'd0, o_err}, 32'd0);

        gap = 0; d0 = done_cnt; w0 = we_cnt;
        wq = {16'h0001, 16'h0002};
        send_pkt(16'h0FFF, 1'b0);
        check("wrap_done", 32'(done_cnt - d0), 32'd1);
        check("mem_fff", 32'(mem[12'hFFF]), 32'h0001);
        check("mem_000", 32'(mem[12'h000]), 32'h0002);

        w0 = we_cnt;
        send(8'hA5); send(8'h00); send(8'h01);
        repeat (10) @(negedge clk);
        check("tmo_busy_mid", {31'd0, o_busy}, 32'd1);
        check("tmo_err_mid", {31'd0, o_err}, 32'd0);
        repeat (10) @(negedge clk);
        check("tmo_busy", {31'd0, o_busy}, 32'd0);
        check("tmo_err", {31'd0, o_err}, 32'd1);
        check("tmo_writes", 32'(we_cnt - w0), 32'd0);

        w0 = we_cnt; d0 = done_cnt;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h00); send(8'h20);
        exp_q.push_back({12'h020, 16'h1122});
        send(8'h11); send(8'h22);
        check("pre_rst_we", {31'd0, o_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dat", 32'(o_dat), 32'd0);
        check("mid_rst_addr", 32'(o_addr), 32'd0);
        check("mid_rst_we", {31'd0, o_we}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_err", {31'd0, o_err}, 32'd0);
        rst = 1'b0;
        send(8'h33); send(8'h44); send(8'h5A); send(8'h66);
        repeat (3) @(negedge clk);
        check("garbage_busy", {31'd0, o_busy}, 32'd0);
        check("rst_writes", 32'(we_cnt - w0), 32'd1);
        check("rst_done_none", 32'(done_cnt - d0), 32'd0);
        check("mem_020", 32'(mem[12'h020]), 32'h1122);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
